fft_bitrev_loader: RTL and testbench

Input stage of the 8-point FFT datapath, directly upstream of the stage-1 butterfly add/sub units. It accepts eight time-domain samples serially over a valid/ready handshake and stores each one at its bit-reversed address. It then presents the stage-1 butterfly operand pairs, two words per beat, over a second valid/ready handshake. Operands are unsigned/two's-complement agnostic words of width 2**N, the same width the butterfly add/sub consumes.

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_bitrev_loader_if.sv | 28 ++
 rtl/fft_bitrev_loader.sv | 74 +++++++
 tb/tb_fft_bitrev_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT datapath: sizes, the loader state
// type and the 3-bit bit-reversal used by the input and later reorder stages.
package fft_pkg;

    localparam int N        = 3;
    localparam int PTS      = 8;
    localparam int LOG2_PTS = 3;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    function automatic logic [LOG2_PTS-1:0] bitrev3(input logic [LOG2_PTS-1:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

endpackage

// File: rtl/fft_bitrev_loader_if.sv
// Sample-in / operand-pair-out handshake bundle of the FFT input loader.
// The slave side is the loader; the master side is its environment.
interface fft_bitrev_loader_if
    import fft_pkg::*;
#(
    parameter int W = 2**N
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic         out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_last
    );

endinterface

// File: rtl/fft_bitrev_loader.sv
// FFT input stage: collects 8 samples at bit-reversed slots, then hands the
// stage-1 butterfly its four operand pairs (even slot, odd slot).
//
// state | meaning
// FILL  | accepting samples, wr_cnt selects the next bit-reversed slot
// DRAIN | presenting pair rd_cnt, upstream held off
module fft_bitrev_loader
    import fft_pkg::*;
#(
    parameter int N = fft_pkg::N
) (
    input  logic                clk,
    input  logic                rst,
    fft_bitrev_loader_if.slave  io
);

    localparam int W = 2**N;

    state_e                state_q, state_d;
    logic [LOG2_PTS-1:0]   wr_cnt_q, wr_cnt_d;
    logic [1:0]            rd_cnt_q, rd_cnt_d;
    logic [W-1:0]          mem_q [PTS];
    logic [W-1:0]          mem_d [PTS];

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        mem_d    = mem_q;
        case (state_q)
            FILL: begin
                if (io.in_valid) begin
                    mem_d[bitrev3(wr_cnt_q)] = io.in_data;
                    wr_cnt_d = wr_cnt_q + 3'd1;
                    if (wr_cnt_q == 3'd7) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (io.out_ready) begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                    if (rd_cnt_q == 2'd3) begin
                        state_d = FILL;
                    end
                end
            end
        endcase
    end

    // Reset clears the buffer too, so a discarded partial frame can never leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            for (int i = 0; i < PTS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            mem_q    <= mem_d;
        end
    end

    assign io.in_ready  = (state_q == FILL);
    assign io.out_valid = (state_q == DRAIN);
    assign io.out_a     = mem_q[{rd_cnt_q, 1'b0}];
    assign io.out_b     = mem_q[{rd_cnt_q, 1'b1}];
    assign io.out_last  = (state_q == DRAIN) && (rd_cnt_q == 2'd3);

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Bench for fft_bitrev_loader: frames in, operand pairs out, compared against
// the bit-reversed pairing rule.
module tb_fft_bitrev_loader;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fft_bitrev_loader_if #(.W(8)) bus ();

    fft_bitrev_loader #(.N(3)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    logic [7:0] frm [8];
    logic [7:0] got_a [$];
    logic [7:0] got_b [$];
    logic       got_l [$];
    logic [7:0] exp_w [$];
    logic       ov_before_last;
    logic       ov_after_last;

    // Slot j of the buffer holds sample rev(j); output word j is slot j.
    function automatic int rev_idx(input int i);
        return (i % 2) * 4 + ((i / 2) % 2) * 2 + (i / 4);
    endfunction

    task automatic push_expected();
        for (int j = 0; j < 8; j++) exp_w.push_back(frm[rev_idx(j)]);
    endtask

    task automatic clear_all();
        got_a.delete(); got_b.delete(); got_l.delete(); exp_w.delete();
    endtask

    // mode 0: back-to-back, 1: alternating gaps, 2: random gaps
    task automatic send_frame(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = frm[i];
            if (i == n - 1) ov_before_last = bus.out_valid;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            if (i == n - 1) ov_after_last = bus.out_valid;
            if ((mode == 1 && i < n - 1) || (mode == 2 && $urandom_range(0, 1) == 1)) begin
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic drain_pairs(input int n, input bit rand_ready);
        int got    = 0;
        int budget = 0;
        while (got < n && budget < 200) begin
            bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                got_a.push_back(bus.out_a);
                got_b.push_back(bus.out_b);
                got_l.push_back(bus.out_last);
                got++;
            end
            @(posedge clk); #1;
            budget++;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic check_pairs(input string name, input int first_pair, input int n);
        for (int k = 0; k < n; k++) begin
            int p = first_pair + k;
            logic [7:0] ea = exp_w[2*p];
            logic [7:0] eb = exp_w[2*p+1];
            logic       el = ((p % 4) == 3);
            total++;
            if (k >= got_a.size()) begin
                bad++;
                $display("FAIL %s pair%0d: missing, got %0d pairs, need %0d", name, k, got_a.size(), n);
            end else if ({got_a[k], got_b[k], got_l[k]} !== {ea, eb, el}) begin
                bad++;
                $display("FAIL %s pair%0d: got a=%h b=%h last=%b, need a=%h b=%h last=%b",
                         name, k, got_a[k], got_b[k], got_l[k], ea, eb, el);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.out_a, bus.out_b, bus.out_last} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset: got rdy=%b vld=%b a=%h b=%h last=%b, need 1 0 00 00 0",
                     bus.in_ready, bus.out_valid, bus.out_a, bus.out_b, bus.out_last);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] ca [4] = '{8'h10, 8'h12, 8'h11, 8'h13};
        logic [7:0] cb [4] = '{8'h14, 8'h16, 8'h15, 8'h17};
        clear_all();
        for (int i = 0; i < 8; i++) frm[i] = 8'h10 + 8'(i);
        send_frame(8, 0);
        drain_pairs(4, 1'b0);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic in_ready after last: got %b need 1", bus.in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= got_a.size()) begin
                bad++;
                $display("FAIL basic pair%0d: missing", k);
            end else if ({got_a[k], got_b[k], got_l[k]} !== {ca[k], cb[k], (k == 3)}) begin
                bad++;
                $display("FAIL basic pair%0d: got %h,%h last=%b need %h,%h last=%b",
                         k, got_a[k], got_b[k], got_l[k], ca[k], cb[k], (k == 3));
            end
        end
    endtask

    task automatic test_gapped();
        clear_all();
        for (int i = 0; i < 8; i++) frm[i] = 8'(i + 1);
        push_expected();
        send_frame(8, 1);
        total++;
        if ({ov_before_last, ov_after_last} !== 2'b01) begin
            bad++;
            $display("FAIL gapped out_valid rise: got before=%b after=%b need 0 1", ov_before_last, ov_after_last);
        end
        drain_pairs(4, 1'b0);
        check_pairs("gapped", 0, 4);
        total++;
        if (got_a.size() > 0 && {got_a[0], got_b[0]} !== {8'h01, 8'h05}) begin
            bad++;
            $display("FAIL gapped first pair: got %h,%h need 01,05", got_a[0], got_b[0]);
        end
    endtask

    task automatic test_stall();
        clear_all();
        for (int i = 0; i < 8; i++) frm[i] = 8'h10 + 8'(i);
        push_expected();
        send_frame(8, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if ({bus.out_valid, bus.out_a, bus.out_b, bus.out_last} !== {1'b1, 8'h12, 8'h16, 1'b0}) begin
                bad++;
                $display("FAIL stall hold c%0d: got vld=%b %h,%h last=%b need 1 12,16 0",
                         c, bus.out_valid, bus.out_a, bus.out_b, bus.out_last);
            end
        end
        drain_pairs(3, 1'b0);
        check_pairs("stall", 1, 3);
    endtask

    task automatic test_drain_ignore();
        clear_all();
        for (int i = 0; i < 8; i++) frm[i] = 8'($urandom_range(0, 254));
        push_expected();
        send_frame(8, 0);
        bus.in_valid = 1'b1; bus.in_data = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if ({bus.in_ready, bus.out_valid} !== 2'b01) begin
                bad++;
                $display("FAIL drain in_ready c%0d: got rdy=%b vld=%b need 0 1", c, bus.in_ready, bus.out_valid);
            end
        end
        bus.in_valid = 1'b0; bus.in_data = '0;
        drain_pairs(4, 1'b0);
        check_pairs("drain_ignore f1", 0, 4);
        clear_all();
        for (int i = 0; i < 8; i++) frm[i] = 8'($urandom_range(0, 254));
        push_expected();
        send_frame(8, 0);
        drain_pairs(4, 1'b0);
        check_pairs("drain_ignore f2", 0, 4);
    endtask

    task automatic test_mid_reset();
        clear_all();
        for (int i = 0; i < 8; i++) frm[i] = 8'h30 + 8'(i);
        send_frame(5, 0);
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h55;
        @(posedge clk); #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.out_a, bus.out_b, bus.out_last} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset outputs: got rdy=%b vld=%b a=%h b=%h last=%b, need 1 0 00 00 0",
                     bus.in_ready, bus.out_valid, bus.out_a, bus.out_b, bus.out_last);
        end
        rst = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) frm[i] = 8'hA0 + 8'(i);
        push_expected();
        send_frame(8, 0);
        total++;
        if (ov_after_last !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset frame length: out_valid after 8 accepts got %b need 1", ov_after_last);
        end
        drain_pairs(4, 1'b0);
        check_pairs("mid_reset", 0, 4);
    endtask

    task automatic test_random_frames();
        int lasts = 0;
        clear_all();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) frm[i] = 8'($urandom_range(0, 255));
            push_expected();
            send_frame(8, 2);
            drain_pairs(4, 1'b1);
        end
        check_pairs("random", 0, 8);
        foreach (got_l[k]) if (got_l[k]) lasts++;
        total++;
        if (lasts != 2) begin
            bad++;
            $display("FAIL random last count: got %0d need 2", lasts);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_stall();
        test_drain_ignore();
        test_mid_reset();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
